// File: rtl/spi_master.sv
// Byte-oriented mode-0 SPI master with per-device active-low chip selects and held-select chaining.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a `loopback` input that routes mosi back to the receiver.
module spi_master #(
    parameter int NUM_CS    = 8,
    parameter int CS_WIDTH  = 3,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 xfer_start,
    input  logic [7:0]           xfer_data,
    input  logic [CS_WIDTH-1:0]  xfer_cs,
    input  logic                 xfer_hold,
    input  logic                 cs_release,
    output logic                 xfer_busy,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [NUM_CS-1:0]    ncs
);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [CS_WIDTH-1:0]  cs_q, cs_d;
    logic                 hold_q, hold_d;
    logic                 gap_q, gap_d;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic                 lb_q, lb_d;
`endif

    logic                 accept;
    logic                 half_done;
    logic                 sample;
    logic                 sel_on_d;
    logic                 sclk_d, mosi_d, busy_d, rx_valid_d;
    logic [7:0]           rx_data_d;
    logic [NUM_CS-1:0]    ncs_d;

    // NOTE: every signal written here is given a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        cs_d      = cs_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        rx_data_d = rx_data;
        mosi_d    = mosi;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d      = lb_q;
        sample    = lb_q ? mosi : miso;
`else
        sample    = miso;
`endif

        half_done = (cnt_q == div_q);
        accept    = xfer_start && ((state_q == IDLE) || (state_q == HELD));

        if (accept) begin
            div_d  = divider;
            cnt_d  = '0;
            bit_d  = 3'd7;
            tx_d   = xfer_data;
            cs_d   = xfer_cs;
            hold_d = xfer_hold;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_d   = loopback;
`endif
        end

        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    state_d = SETUP;
                    gap_d   = 1'b0;
                end
            end
            HELD: begin
                // Start beats release; a new target first sees a deselect gap.
                if (xfer_start) begin
                    if (xfer_cs == cs_q) begin
                        state_d = SHIFT_LO;
                        mosi_d  = xfer_data[7];
                    end else begin
                        state_d = SETUP;
                        gap_d   = 1'b1;
                    end
                end else if (cs_release) begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (gap_q) begin
                        gap_d = 1'b0;
                    end else begin
                        state_d = SHIFT_LO;
                        mosi_d  = tx_q[bit_q];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                // miso is taken on the same clk edge that raises sclk.
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HI;
                    rx_sh_d = {rx_sh_q[6:0], sample};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd0) begin
                        state_d   = DONE;
                        rx_data_d = rx_sh_q;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        state_d = SHIFT_LO;
                        mosi_d  = tx_q[bit_d];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = hold_q ? HELD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change cleanly with it.
        sel_on_d = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == HELD) ||
                   ((state_d == SETUP) && !gap_d) || ((state_d == DONE) && hold_d);
        for (int i = 0; i < NUM_CS; i++) begin
            ncs_d[i] = !(sel_on_d && (cs_d == CS_WIDTH'(i)));
        end
        sclk_d     = (state_d == SHIFT_HI);
        busy_d     = (state_d == SETUP) || (state_d == SHIFT_LO) ||
                     (state_d == SHIFT_HI) || (state_d == DONE);
        rx_valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= 3'd7;
            tx_q      <= 8'h00;
            rx_sh_q   <= 8'h00;
            cs_q      <= '0;
            hold_q    <= 1'b0;
            gap_q     <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ncs       <= '1;
            xfer_busy <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            cs_q      <= cs_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q      <= lb_d;
`endif
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            ncs       <= ncs_d;
            xfer_busy <= busy_d;
            rx_valid  <= rx_valid_d;
            rx_data   <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed scenarios plus randomized traffic against a
// cycle-offset reference model of the transfer timeline and a shift-register slave.
module tb_spi_master;

    localparam int NUM_CS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] divider;
    logic       xfer_start;
    logic [7:0] xfer_data;
    logic [2:0] xfer_cs;
    logic       xfer_hold;
    logic       cs_release;
    logic       xfer_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [7:0] ncs;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback;
`endif

    spi_master #(.NUM_CS(NUM_CS), .CS_WIDTH(3), .DIV_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .divider    (divider),
        .xfer_start (xfer_start),
        .xfer_data  (xfer_data),
        .xfer_cs    (xfer_cs),
        .xfer_hold  (xfer_hold),
        .cs_release (cs_release),
        .xfer_busy  (xfer_busy),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .ncs        (ncs)
    );

    always #5 clk = ~clk;

    // Reference model: a transfer is a timeline of P pre-shift half-periods followed by
    // sixteen shift half-periods and one DONE cycle, indexed by offset from the first busy cycle.
    logic       e_sclk, e_mosi, e_busy, e_rxv;
    logic [7:0] e_rxd, e_ncs;
    logic       m_active, m_held, m_hold, m_lb;
    logic [2:0] m_cs;
    logic [7:0] m_data, m_sb;
    int         m_k, m_p, m_h, m_total;
    logic [7:0] slave_byte;

    function automatic logic [7:0] sel(input logic [2:0] cs);
        return ~(8'd1 << cs);
    endfunction

    task model_outputs();
        int j, half;
        logic [7:0] t;
        e_busy = 1'b1;
        e_rxv  = 1'b0;
        if (m_k == m_total) begin
            e_sclk = 1'b0;
            e_rxv  = 1'b1;
            e_rxd  = m_lb ? m_data : m_sb;
            e_ncs  = m_hold ? sel(m_cs) : 8'hFF;
        end else if (m_k < m_p * m_h) begin
            e_sclk = 1'b0;
            e_ncs  = (m_p == 2 && m_k < m_h) ? 8'hFF : sel(m_cs);
        end else begin
            j      = m_k - m_p * m_h;
            half   = j / m_h;
            t      = m_data << (half / 2);
            e_sclk = half[0];
            e_mosi = t[7];
            e_ncs  = sel(m_cs);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_held = 1'b0;
            e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_rxv = 1'b0;
            e_rxd = 8'h00; e_ncs = 8'hFF;
        end else if (m_active) begin
            if (m_k == m_total) begin
                m_active = 1'b0;
                m_held   = m_hold;
                e_busy = 1'b0; e_rxv = 1'b0; e_sclk = 1'b0;
                e_ncs  = m_hold ? sel(m_cs) : 8'hFF;
            end else begin
                m_k++;
                model_outputs();
            end
        end else if (xfer_start) begin
            m_p    = !m_held ? 1 : ((xfer_cs == m_cs) ? 0 : 2);
            m_held = 1'b0;
            m_cs   = xfer_cs;
            m_data = xfer_data;
            m_hold = xfer_hold;
            m_sb   = slave_byte;
`ifdef SPI_MASTER_LOOPBACK_EN
            m_lb   = loopback;
`else
            m_lb   = 1'b0;
`endif
            m_h     = int'(divider) + 1;
            m_total = (m_p + 16) * m_h;
            m_k     = 0;
            m_active = 1'b1;
            model_outputs();
        end else if (m_held && cs_release) begin
            m_held = 1'b0;
            e_ncs  = 8'hFF;
        end
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       chk_en = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [7:0] sl_sh = 8'h00;
    logic [7:0] mon_byte = 8'h00;
    int         mon_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: compare against the model, then run the slave and the mosi monitor.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            check("sclk", 32'(sclk), 32'(e_sclk));
            check("mosi", 32'(mosi), 32'(e_mosi));
            check("ncs", 32'(ncs), 32'(e_ncs));
            check("xfer_busy", 32'(xfer_busy), 32'(e_busy));
            check("rx_valid", 32'(rx_valid), 32'(e_rxv));
            check("rx_data", 32'(rx_data), 32'(e_rxd));
        end
        if (sclk && !prev_sclk) begin
            mon_byte = {mon_byte[6:0], mosi};
            mon_n++;
            sl_sh = sl_sh << 1;
        end
        if (!xfer_busy) sl_sh = slave_byte;
        prev_sclk = sclk;
        miso = sl_sh[7];
    endtask

    task automatic issue(input logic [7:0] d, input logic [2:0] cs, input logic hold,
                         input logic [7:0] div, input logic [7:0] sb, input logic rel,
                         output int n);
        xfer_data = d; xfer_cs = cs; xfer_hold = hold; divider = div;
        slave_byte = sb; sl_sh = sb; miso = sb[7];
        cs_release = rel; xfer_start = 1'b1;
        mon_byte = 8'h00; mon_n = 0;
        n = cyc;
        tick();
        xfer_start = 1'b0; cs_release = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input logic [7:0] exp_ncs, output int at, output int bad);
        at = -1; bad = 0;
        for (int i = 0; i < budget; i++) begin
            if (rx_valid) begin
                at = cyc;
                break;
            end
            if (ncs !== exp_ncs) bad++;
            tick();
        end
        if (at < 0) fail_now("rx_valid wait");
    endtask

    initial begin
        int n, at, bad, pulses;
        logic held;
        logic [2:0] held_cs, cs;
        logic hold;

        rst = 1'b1; divider = 8'd0; xfer_start = 1'b0; xfer_data = 8'h00; xfer_cs = 3'd0;
        xfer_hold = 1'b0; cs_release = 1'b0; miso = 1'b0; slave_byte = 8'h00;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("reset ncs", 32'(ncs), 32'h0FF);
        check("reset busy", 32'(xfer_busy), 32'h0);
        check("reset rx_data", 32'(rx_data), 32'h00);

        // Basic byte: 0xA5 on cs 2, H = 4, slave returns 0x3C.
        issue(8'hA5, 3'd2, 1'b0, 8'd3, 8'h3C, 1'b0, n);
        wait_valid(200, 8'hFB, at, bad);
        check("A5 rx_valid cycle", 32'(at), 32'(n + 1 + 68));
        check("A5 rx_data", 32'(rx_data), 32'h3C);
        check("A5 mosi bits", 32'(mon_byte), 32'hA5);
        check("A5 ncs bad cycles", 32'(bad), 32'd0);
        tick();
        check("A5 ncs after", 32'(ncs), 32'h0FF);
        check("A5 busy drop cycle", 32'(xfer_busy), 32'h0);

        // Held select chaining on cs 5, H = 2.
        issue(8'h01, 3'd5, 1'b1, 8'd1, 8'h80, 1'b0, n);
        wait_valid(200, 8'hDF, at, bad);
        check("hold first ncs bad cycles", 32'(bad), 32'd0);
        check("hold first DONE ncs", 32'(ncs), 32'h0DF);
        tick();
        check("held ncs", 32'(ncs), 32'h0DF);
        check("held busy", 32'(xfer_busy), 32'h0);
        issue(8'h02, 3'd5, 1'b0, 8'd1, 8'h4D, 1'b0, n);
        check("hold second accept ncs", 32'(ncs), 32'h0DF);
        wait_valid(200, 8'hDF, at, bad);
        check("hold second rx_valid cycle", 32'(at), 32'(n + 1 + 32));
        check("hold second ncs bad cycles", 32'(bad), 32'd0);
        check("hold second rx_data", 32'(rx_data), 32'h4D);
        tick();

        // Start and release together from HELD: start wins.
        issue(8'h11, 3'd3, 1'b1, 8'd0, 8'h22, 1'b0, n);
        wait_valid(200, 8'hF7, at, bad);
        tick();
        issue(8'h33, 3'd3, 1'b1, 8'd0, 8'h44, 1'b1, n);
        check("start beats release ncs", 32'(ncs), 32'h0F7);
        check("start beats release busy", 32'(xfer_busy), 32'h1);
        wait_valid(200, 8'hF7, at, bad);
        tick();
        cs_release = 1'b1;
        tick();
        cs_release = 1'b0;
        check("release alone ncs", 32'(ncs), 32'h0FF);

        // Start while busy is ignored.
        issue(8'h00, 3'd1, 1'b0, 8'd0, 8'h99, 1'b0, n);
        xfer_start = 1'b1; xfer_data = 8'hFF;
        tick();
        xfer_start = 1'b0;
        wait_valid(200, 8'hFD, at, bad);
        pulses = (at >= 0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check("busy ignore pulses", 32'(pulses), 32'd1);
        check("busy ignore mosi bits", 32'(mon_byte), 32'h00);
        check("busy ignore rx_data", 32'(rx_data), 32'h99);

        // Reset at the fourth sclk rise.
        issue(8'hC3, 3'd4, 1'b1, 8'd1, 8'h5E, 1'b0, n);
        for (int i = 0; i < 200 && mon_n < 4; i++) tick();
        if (mon_n < 4) fail_now("fourth sclk rise");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset ncs", 32'(ncs), 32'h0FF);
        check("mid reset sclk", 32'(sclk), 32'h0);
        check("mid reset busy", 32'(xfer_busy), 32'h0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check("mid reset rx_valid pulses", 32'(pulses), 32'd0);

`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b1;
        issue(8'h5A, 3'd0, 1'b0, 8'd1, 8'h00, 1'b0, n);
        loopback = 1'b0;
        wait_valid(200, 8'hFE, at, bad);
        check("loopback rx_data", 32'(rx_data), 32'h5A);
        tick();
`endif

        // Randomized traffic.
        held = 1'b0; held_cs = 3'd0;
        for (int t = 0; t < 60; t++) begin
            if (held && $urandom_range(0, 3) == 0) begin
                cs_release = 1'b1;
                tick();
                cs_release = 1'b0;
                held = 1'b0;
            end
            cs   = (held && $urandom_range(0, 1) == 1) ? held_cs : 3'($urandom_range(0, 7));
            hold = 1'($urandom_range(0, 1));
            issue(8'($urandom), cs, hold, 8'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), n);
            if ($urandom_range(0, 2) == 0) begin
                xfer_start = 1'b1; xfer_data = 8'($urandom); divider = 8'($urandom_range(0, 3));
                xfer_cs = 3'($urandom_range(0, 7));
                tick();
                xfer_start = 1'b0;
            end
            wait_valid(400, 8'hFF, at, bad);
            tick();
            held = hold; held_cs = cs;
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
